sobel_row_fetch: RTL and testbench

Reads successive input-image rows from memory and drives the three-row window (`srow2sacc_row{1,2,3}_data`) consumed by the Sobel accelerator core. It primes three rows, then presents one window per valid/ready handshake. After each handshake it slides the window down by one row and fetches the next row. It sits between the memory read port and the combinational accelerator core, mirroring the write-side path that drains `sacc2swt_write_data`.

---
 rtl/sobel_row_fetch_pkg.sv | 24 ++
 rtl/sobel_row_fetch_shift.sv | 28 ++
 rtl/sobel_row_fetch.sv | 163 ++++++++++++++++
 tb/tb_sobel_row_fetch.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_row_fetch_pkg.sv
// Shared definitions for the Sobel row-fetch block: default widths,
// accelerator-derived data width and the fetch FSM state encoding.
package sobel_row_fetch_pkg;

    // Each accelerator lane needs one pixel of its own plus one neighbour on
    // each side, so a row chunk is (lanes + 2) bytes wide.
    localparam int NUM_SOBEL_ACCELERATORS = 4;
    localparam int SOBEL_IDATA_WIDTH      = (NUM_SOBEL_ACCELERATORS + 2) * 8;

    localparam int SRF_ADDR_W = 32;
    localparam int SRF_CNT_W  = 16;

    // A 3x3 kernel needs three rows before the first window exists.
    localparam int SRF_MIN_ROWS = 3;

    typedef enum logic [2:0] {
        SRF_IDLE    = 3'd0,
        SRF_REQ     = 3'd1,
        SRF_WAIT    = 3'd2,
        SRF_PRESENT = 3'd3,
        SRF_DONE    = 3'd4
    } srf_state_t;

endpackage

// File: rtl/sobel_row_fetch_shift.sv
// Three-row sliding window storage. A load shifts every row up by one and
// places the incoming row at the bottom; otherwise contents are held.
module sobel_row_shift #(
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] row1,
    output logic [DATA_W-1:0] row2,
    output logic [DATA_W-1:0] row3
);

    // Shift the window down one image row on each captured read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row1 <= '0;
            row2 <= '0;
            row3 <= '0;
        end else if (load) begin
            row1 <= row2;
            row2 <= row3;
            row3 <= din;
        end
    end

endmodule

// File: rtl/sobel_row_fetch.sv
// Row fetcher feeding the Sobel accelerator core. Reads image rows one at a
// time, keeps the last three in a sliding window and offers one window per
// valid/ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for go; row window holds its last contents
//   REQ     | read request on the memory port for exactly one cycle
//   WAIT    | waiting for read data; capture shifts the window
//   PRESENT | window valid, held stable until the consumer takes it
//   DONE    | one-cycle done pulse, then back to IDLE
module sobel_row_fetch
    import sobel_row_fetch_pkg::*;
#(
    parameter int DATA_W = SOBEL_IDATA_WIDTH,
    parameter int ADDR_W = SRF_ADDR_W,
    parameter int CNT_W  = SRF_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              go,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [ADDR_W-1:0] cfg_row_stride,
    input  logic [CNT_W-1:0]  cfg_num_rows,
    output logic              srf2mem_rd_en,
    output logic [ADDR_W-1:0] srf2mem_rd_addr,
    input  logic              mem2srf_rd_valid,
    input  logic [DATA_W-1:0] mem2srf_rd_data,
    output logic [DATA_W-1:0] srow2sacc_row1_data,
    output logic [DATA_W-1:0] srow2sacc_row2_data,
    output logic [DATA_W-1:0] srow2sacc_row3_data,
    output logic              srow2sacc_valid,
    input  logic              sacc2srow_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    srf_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] stride;
    logic [ADDR_W-1:0] addr_next;
    logic [CNT_W-1:0]  rows_fetched;
    logic [CNT_W-1:0]  fetched_next;
    logic [CNT_W-1:0]  win_left;
    logic              row_load;
    logic              too_few_rows;
    logic              handshake;

    // Address arithmetic wraps modulo 2^ADDR_W on purpose.
    assign addr_next    = addr + stride;
    assign fetched_next = rows_fetched + CNT_W'(1);
    assign too_few_rows = cfg_num_rows < CNT_W'(SRF_MIN_ROWS);
    assign handshake    = srow2sacc_valid && sacc2srow_ready;

    // Read data only counts while a request is outstanding; anything else
    // (stale data after reset, stray pulses) is dropped here.
    assign row_load = (state == SRF_WAIT) && mem2srf_rd_valid;

    sobel_row_shift #(
        .DATA_W (DATA_W)
    ) u_row_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (row_load),
        .din     (mem2srf_rd_data),
        .row1    (srow2sacc_row1_data),
        .row2    (srow2sacc_row2_data),
        .row3    (srow2sacc_row3_data)
    );

    // Fetch sequencer with registered control outputs. Outputs are set on
    // the transition into the state that owns them so each is a plain flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= SRF_IDLE;
            addr            <= '0;
            stride          <= '0;
            rows_fetched    <= '0;
            win_left        <= '0;
            srf2mem_rd_en   <= 1'b0;
            srf2mem_rd_addr <= '0;
            srow2sacc_valid <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            srf2mem_rd_en <= 1'b0;
            done          <= 1'b0;

            case (state)
                SRF_IDLE: begin
                    if (go) begin
                        addr         <= cfg_base_addr;
                        stride       <= cfg_row_stride;
                        rows_fetched <= '0;
                        busy         <= 1'b1;
                        if (too_few_rows) begin
                            // No full window exists: report and finish
                            // without touching memory.
                            win_left <= '0;
                            err      <= 1'b1;
                            done     <= 1'b1;
                            state    <= SRF_DONE;
                        end else begin
                            win_left        <= cfg_num_rows - CNT_W'(2);
                            err             <= 1'b0;
                            srf2mem_rd_en   <= 1'b1;
                            srf2mem_rd_addr <= cfg_base_addr;
                            state           <= SRF_REQ;
                        end
                    end
                end

                SRF_REQ: begin
                    state <= SRF_WAIT;
                end

                SRF_WAIT: begin
                    if (mem2srf_rd_valid) begin
                        rows_fetched <= fetched_next;
                        addr         <= addr_next;
                        if (fetched_next >= CNT_W'(SRF_MIN_ROWS)) begin
                            srow2sacc_valid <= 1'b1;
                            state           <= SRF_PRESENT;
                        end else begin
                            srf2mem_rd_en   <= 1'b1;
                            srf2mem_rd_addr <= addr_next;
                            state           <= SRF_REQ;
                        end
                    end
                end

                SRF_PRESENT: begin
                    if (handshake) begin
                        srow2sacc_valid <= 1'b0;
                        win_left        <= win_left - CNT_W'(1);
                        if (win_left == CNT_W'(1)) begin
                            done  <= 1'b1;
                            state <= SRF_DONE;
                        end else begin
                            srf2mem_rd_en   <= 1'b1;
                            srf2mem_rd_addr <= addr;
                            state           <= SRF_REQ;
                        end
                    end
                end

                SRF_DONE: begin
                    busy  <= 1'b0;
                    state <= SRF_IDLE;
                end

                default: begin
                    srow2sacc_valid <= 1'b0;
                    busy            <= 1'b0;
                    state           <= SRF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_row_fetch.sv
// Self-checking bench for sobel_row_fetch: memory model with programmable
// latency, scoreboard of expected read addresses and windows.
module tb_sobel_row_fetch;
    import sobel_row_fetch_pkg::*;

    localparam int DW = SOBEL_IDATA_WIDTH;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          go = 1'b0;
    logic [31:0]   cfg_base_addr = '0;
    logic [31:0]   cfg_row_stride = '0;
    logic [15:0]   cfg_num_rows = '0;
    logic          srf2mem_rd_en;
    logic [31:0]   srf2mem_rd_addr;
    logic          mem2srf_rd_valid = 1'b0;
    logic [DW-1:0] mem2srf_rd_data = '0;
    logic [DW-1:0] srow2sacc_row1_data;
    logic [DW-1:0] srow2sacc_row2_data;
    logic [DW-1:0] srow2sacc_row3_data;
    logic          srow2sacc_valid;
    logic          sacc2srow_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          err;

    sobel_row_fetch dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .go                  (go),
        .cfg_base_addr       (cfg_base_addr),
        .cfg_row_stride      (cfg_row_stride),
        .cfg_num_rows        (cfg_num_rows),
        .srf2mem_rd_en       (srf2mem_rd_en),
        .srf2mem_rd_addr     (srf2mem_rd_addr),
        .mem2srf_rd_valid    (mem2srf_rd_valid),
        .mem2srf_rd_data     (mem2srf_rd_data),
        .srow2sacc_row1_data (srow2sacc_row1_data),
        .srow2sacc_row2_data (srow2sacc_row2_data),
        .srow2sacc_row3_data (srow2sacc_row3_data),
        .srow2sacc_valid     (srow2sacc_valid),
        .sacc2srow_ready     (sacc2srow_ready),
        .busy                (busy),
        .done                (done),
        .err                 (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] stride;
        logic [15:0] rows;
        int          lmode;
        int          exp_win;
        bit          exp_err;
        bit          stray;
    } vec_t;

    typedef struct {
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic [DW-1:0] r3;
    } win_t;

    win_t        exp_win_q[$];
    logic [31:0] exp_addr_q[$];
    int          hs_q[$];

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int win_cnt = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int first_valid_cyc = -1;
    int w0 = 0;
    int d0 = 0;
    int r0 = 0;

    int            lat_mode = 0;
    int            req_idx = 0;
    int            pend = 0;
    int            lat_now = 1;
    logic [DW-1:0] pend_data = '0;
    bit            stray_req = 1'b0;

    win_t        mw;
    logic [31:0] ea;

    function automatic logic [DW-1:0] row_val(input logic [31:0] a);
        return DW'({a[15:0], ~a[15:0], a[31:16] ^ 16'h5a5a});
    endfunction

    function automatic void chk(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    always @(posedge clk) cyc++;

    // Memory model: answers each request after the configured latency,
    // and can inject one stray valid pulse when nothing is pending.
    always @(negedge clk) begin
        mem2srf_rd_valid = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                mem2srf_rd_valid = 1'b1;
                mem2srf_rd_data  = pend_data;
            end
        end else if (stray_req) begin
            mem2srf_rd_valid = 1'b1;
            mem2srf_rd_data  = DW'(48'hDEAD_BEEF_F00D);
            stray_req        = 1'b0;
        end
        if (srf2mem_rd_en) begin
            if (lat_mode == 1)                       lat_now = 4;
            else if (lat_mode == 2 && req_idx % 2 == 1) lat_now = 4;
            else                                     lat_now = 1;
            req_idx++;
            pend      = lat_now;
            pend_data = row_val(srf2mem_rd_addr);
        end
    end

    // Monitor: reads and windows are checked against the scoreboard.
    always @(negedge clk) begin
        #1;
        if (reset_n) begin
            if (srf2mem_rd_en) begin
                rd_cnt++;
                if (exp_addr_q.size() == 0) begin
                    chk(1'b0, "unexpected_read", 64'(srf2mem_rd_addr), 64'(0));
                end else begin
                    ea = exp_addr_q.pop_front();
                    chk(srf2mem_rd_addr == ea, "rd_addr", 64'(srf2mem_rd_addr), 64'(ea));
                end
            end
            if (srow2sacc_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (sacc2srow_ready) begin
                    win_cnt++;
                    hs_q.push_back(cyc);
                    if (exp_win_q.size() == 0) begin
                        chk(1'b0, "unexpected_window", 64'(srow2sacc_row1_data), 64'(0));
                    end else begin
                        mw = exp_win_q.pop_front();
                        chk(srow2sacc_row1_data == mw.r1, "win_row1", 64'(srow2sacc_row1_data), 64'(mw.r1));
                        chk(srow2sacc_row2_data == mw.r2, "win_row2", 64'(srow2sacc_row2_data), 64'(mw.r2));
                        chk(srow2sacc_row3_data == mw.r3, "win_row3", 64'(srow2sacc_row3_data), 64'(mw.r3));
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk(!srow2sacc_valid, "valid_in_done", 64'(srow2sacc_valid), 64'(0));
            end
        end
    end

    task automatic start_strip(input vec_t v, output int c0);
        int n;
        win_t w;
        n = int'(v.rows);
        if (n >= 3) begin
            for (int i = 0; i < n; i++) exp_addr_q.push_back(v.base + 32'(i) * v.stride);
            for (int k = 0; k + 2 < n; k++) begin
                w.r1 = row_val(v.base + 32'(k) * v.stride);
                w.r2 = row_val(v.base + 32'(k + 1) * v.stride);
                w.r3 = row_val(v.base + 32'(k + 2) * v.stride);
                exp_win_q.push_back(w);
            end
        end
        lat_mode = v.lmode;
        req_idx = 0;
        first_valid_cyc = -1;
        hs_q.delete();
        w0 = win_cnt;
        d0 = done_cnt;
        r0 = rd_cnt;
        if (v.stray) begin
            stray_req = 1'b1;
            repeat (2) @(negedge clk);
        end
        @(negedge clk);
        cfg_base_addr  = v.base;
        cfg_row_stride = v.stride;
        cfg_num_rows   = v.rows;
        go = 1'b1;
        c0 = cyc;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic end_strip(input vec_t v, input string name, input int c0, input bit timing);
        int n;
        int lat;
        int exp_rd;
        n = int'(v.rows);
        exp_rd = (n >= 3) ? n : 0;
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clk);
        chk(done_cnt != d0, {name, "_done_timeout"}, 64'(done_cnt), 64'(d0 + 1));
        repeat (3) @(negedge clk);
        #2;
        chk(done_cnt == d0 + 1, {name, "_done_pulses"}, 64'(done_cnt - d0), 64'(1));
        chk(win_cnt - w0 == v.exp_win, {name, "_windows"}, 64'(win_cnt - w0), 64'(v.exp_win));
        chk(rd_cnt - r0 == exp_rd, {name, "_reads"}, 64'(rd_cnt - r0), 64'(exp_rd));
        chk(err == v.exp_err, {name, "_err"}, 64'(err), 64'(v.exp_err));
        chk(exp_win_q.size() == 0 && exp_addr_q.size() == 0, {name, "_scoreboard_drained"},
            64'(exp_win_q.size() + exp_addr_q.size()), 64'(0));
        chk(!busy, {name, "_busy_idle"}, 64'(busy), 64'(0));
        if (v.exp_err) begin
            chk(done_cyc - c0 == 1, {name, "_degenerate_done_cycle"}, 64'(done_cyc - c0), 64'(1));
        end else begin
            chk(srow2sacc_row3_data == row_val(v.base + 32'(n - 1) * v.stride), {name, "_rows_retained"},
                64'(srow2sacc_row3_data), 64'(row_val(v.base + 32'(n - 1) * v.stride)));
        end
        if (timing && !v.exp_err) begin
            lat = (v.lmode == 1) ? 4 : 1;
            chk(first_valid_cyc - c0 == 3 * (lat + 1) + 1, {name, "_first_valid_cycle"},
                64'(first_valid_cyc - c0), 64'(3 * (lat + 1) + 1));
            if (v.exp_win >= 2 && hs_q.size() >= 2)
                chk(hs_q[1] - hs_q[0] == lat + 2, {name, "_window_period"},
                    64'(hs_q[1] - hs_q[0]), 64'(lat + 2));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int c0;
        int rc;
        bit hold_ok;
        logic [DW-1:0] h1, h2, h3;

        vecs[0] = '{32'h0000_1000, 32'h100, 16'd5, 0, 3, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_2000, 32'h040, 16'd2, 0, 0, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_3000, 32'h040, 16'd3, 0, 1, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_4000, 32'h080, 16'd6, 2, 4, 1'b0, 1'b1};
        vecs[4] = '{32'hFFFF_FF00, 32'h100, 16'd3, 0, 1, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_5000, 32'h010, 16'd0, 0, 0, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_5800, 32'h020, 16'd4, 1, 2, 1'b0, 1'b0};

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        chk({srf2mem_rd_en, srow2sacc_valid, done, err, busy} == 5'b0, "reset_ctrl",
            64'({srf2mem_rd_en, srow2sacc_valid, done, err, busy}), 64'(0));
        chk(srf2mem_rd_addr == 32'h0, "reset_rd_addr", 64'(srf2mem_rd_addr), 64'(0));
        chk((srow2sacc_row1_data | srow2sacc_row2_data | srow2sacc_row3_data) == '0, "reset_rows",
            64'(srow2sacc_row1_data | srow2sacc_row2_data | srow2sacc_row3_data), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            start_strip(vecs[i], c0);
            end_strip(vecs[i], $sformatf("vec%0d", i), c0, vecs[i].lmode != 2);
        end

        // Backpressure on window 2 with a stray response while presenting.
        v = '{32'h0000_8000, 32'h040, 16'd5, 0, 3, 1'b0, 1'b0};
        start_strip(v, c0);
        for (int i = 0; i < 200 && win_cnt == w0; i++) @(negedge clk);
        sacc2srow_ready = 1'b0;
        for (int i = 0; i < 200 && !srow2sacc_valid; i++) @(negedge clk);
        #2;
        chk(srow2sacc_valid, "bp_valid_reached", 64'(srow2sacc_valid), 64'(1));
        h1 = srow2sacc_row1_data;
        h2 = srow2sacc_row2_data;
        h3 = srow2sacc_row3_data;
        rc = rd_cnt;
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) stray_req = 1'b1;
            @(negedge clk);
            #2;
            if (!srow2sacc_valid || srow2sacc_row1_data != h1 ||
                srow2sacc_row2_data != h2 || srow2sacc_row3_data != h3) hold_ok = 1'b0;
        end
        chk(hold_ok, "bp_window_held", 64'(hold_ok), 64'(1));
        chk(rd_cnt == rc, "bp_no_read", 64'(rd_cnt - rc), 64'(0));
        @(negedge clk);
        sacc2srow_ready = 1'b1;
        end_strip(v, "bp", c0, 1'b0);

        // go while busy, with different cfg, must be ignored.
        v = '{32'h0000_7000, 32'h020, 16'd4, 0, 2, 1'b0, 1'b0};
        start_strip(v, c0);
        for (int i = 0; i < 200 && rd_cnt == r0; i++) @(negedge clk);
        @(negedge clk);
        cfg_base_addr  = 32'h0000_9000;
        cfg_row_stride = 32'h10;
        cfg_num_rows   = 16'd10;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        end_strip(v, "busy_go", c0, 1'b0);

        // Reset during WAIT; the late response must not load anything.
        v = '{32'h0000_A000, 32'h010, 16'd5, 1, 3, 1'b0, 1'b0};
        start_strip(v, c0);
        for (int i = 0; i < 200 && rd_cnt < r0 + 2; i++) @(negedge clk);
        chk(rd_cnt >= r0 + 2, "rst_reads_reached", 64'(rd_cnt - r0), 64'(2));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk({srf2mem_rd_en, srow2sacc_valid, done, err, busy} == 5'b0, "rst_async_ctrl",
            64'({srf2mem_rd_en, srow2sacc_valid, done, err, busy}), 64'(0));
        chk(srf2mem_rd_addr == 32'h0, "rst_async_rd_addr", 64'(srf2mem_rd_addr), 64'(0));
        chk((srow2sacc_row1_data | srow2sacc_row2_data | srow2sacc_row3_data) == '0, "rst_async_rows",
            64'(srow2sacc_row1_data | srow2sacc_row2_data | srow2sacc_row3_data), 64'(0));
        exp_addr_q.delete();
        exp_win_q.delete();
        d0 = done_cnt;
        rc = rd_cnt;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        chk(done_cnt == d0, "rst_no_done", 64'(done_cnt - d0), 64'(0));
        chk(rd_cnt == rc, "rst_no_read", 64'(rd_cnt - rc), 64'(0));
        chk(!srow2sacc_valid && !busy, "rst_stays_idle", 64'({srow2sacc_valid, busy}), 64'(0));
        chk(srow2sacc_row3_data == '0, "rst_stale_ignored", 64'(srow2sacc_row3_data), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
